pu_alu_issue: RTL
=================

Name: pu_alu_issue

Overview:
- Instruction-driven issue and sequencing front end for the PU ALU.
- Accepts 32-bit PU ALU instruction words and repeats each over N operand pairs from an input stream.
- Drives the ALU control/operand interface (fn_valid, fn, imm, alu_in1_src, alu_in0, alu_in1) and returns the registered ALU result as a valid/ready output stream with a per-instruction last flag.

Parameters:
- DATA_WIDTH, 16, width of operand 1 and of the ALU's alu_in1.
- ACC_DATA_WIDTH, 32, width of operand 0, the ALU result and out_data.
- IMM_WIDTH, 16, immediate width; fixed at 16 by the instruction format.
- FN_WIDTH, 3, ALU function code width.
- REPEAT_WIDTH, 12, width of the repeat field.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_valid  in  1  instruction word valid
- inst_ready  out  1  instruction accepted when inst_valid && inst_ready
- inst  in  32  [31:29] fn, [28] src (1 = imm), [27:16] repeat (element count = repeat+1), [15:0] imm
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair consumed
- in_data0  in  ACC_DATA_WIDTH  operand 0
- in_data1  in  DATA_WIDTH  operand 1
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  ACC_DATA_WIDTH  result, equal to alu_out
- out_last  out  1  result belongs to the last element of its instruction
- busy  out  1  instruction active or result pending
- fn_valid  out  1  ALU register enable
- fn  out  FN_WIDTH  ALU function
- imm  out  IMM_WIDTH  ALU immediate
- alu_in1_src  out  1  ALU operand-1 select
- alu_in0  out  ACC_DATA_WIDTH  ALU operand 0
- alu_in1  out  DATA_WIDTH  ALU operand 1
- alu_out  in  ACC_DATA_WIDTH  ALU registered result, 1-cycle latency after fn_valid

Behaviour:
- One clock (clk). Asynchronous active-high reset.
- Reset values: state=IDLE, inst_ready=1, in_ready=0, out_valid=0, out_last=0, busy=0, fn_valid=0. The fn, imm and src registers reset to 0.
- FSM states are IDLE and RUN.
- IDLE:
  - inst_ready=1.
  - On handshake, latch fn, src, imm and count=repeat, then go to RUN.
  - There is no issue in the accept cycle.
- RUN:
  - inst_ready=0.
  - in_ready = (!out_valid || out_ready).
  - An issue occurs in a cycle with in_valid && in_ready.
  - On issue: fn_valid=1 (combinational, same cycle), alu_in0=in_data0, alu_in1=in_data1, fn/imm/alu_in1_src from the latched registers.
  - If count==0, the issue is last: go to IDLE. Otherwise decrement count.
- Outside an issue cycle, fn_valid=0 and the ALU holds its result.
- Result stage:
  - out_valid is set the cycle after an issue; out_last is registered with it.
  - out_valid is cleared on out_valid && out_ready with no new issue that cycle.
  - out_data = alu_out, combinational passthrough. It is stable while out_valid is high because issue is blocked until drain.
- Back-to-back throughput: one element per cycle while out_ready=1.
- repeat=0 runs exactly one element with out_last=1.
- repeat=4095 runs 4096 elements; count never wraps.
- The next instruction is accepted in IDLE while the previous result is still pending. The new instruction's first issue still waits for drain via in_ready.
- busy = (state==RUN) || out_valid.
- All fn codes 0-7 are passed through unchecked. For MVHI, operands are still consumed one per element.
- Reset mid-instruction: the instruction is abandoned, the pending result is dropped and the FSM returns to IDLE.

Optional Feature:
- Macro: PU_ALU_ISSUE_STATS_EN.
- With the macro: adds outputs stat_issue_count[31:0] and stat_stall_count[31:0], both reset to 0 and free-running with wrap.
  - stat_issue_count increments on each issue.
  - stat_stall_count increments each RUN cycle with in_valid && !in_ready.
- Without the macro: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pu_pkg holds:
  - FN_* codes: NOP=0, ADD=1, SUB=2, MUL=3, MVHI=4, MAX=5, MIN=6, RSHIFT=7.
  - Instruction field offsets and widths.
  - State encodings.
- One natural sub-module, pu_inst_decode: combinational field extraction of fn, src, repeat and imm from inst.

Test Plan:
- Reset mid-instruction: assert reset while RUN with count=3 → out_valid=0, inst_ready=1 and fn_valid=0 immediately, without waiting for a clock edge.
- Single ADD, src=1, imm=5, repeat=0, in_data0=10 → one fn_valid pulse with fn=1, alu_in1_src=1, imm=5; a model ALU returns 15; out_valid and out_last next cycle with out_data=15.
- MUL, repeat=3, four pairs (2,3),(4,5),(6,7),(8,9), out_ready=1 → four consecutive fn_valid cycles, results 6,20,42,72, out_last only on 72, then inst_ready=1.
- Backpressure: SUB, repeat=2, out_ready=0 for 3 cycles after the first result → in_ready=0, fn_valid=0, out_data held; sequence resumes after release with no loss or duplication.
- RSHIFT, src=0, alu_in1=4, in_data0=-256 → fn=7 issued, out_data=-16. Then a new instruction is accepted one cycle after the prior last issue.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared definitions for the PU ALU issue front end:
// function codes, instruction field layout, FSM state encodings.
package pu_pkg;

  localparam logic [2:0] FN_NOP    = 3'd0;
  localparam logic [2:0] FN_ADD    = 3'd1;
  localparam logic [2:0] FN_SUB    = 3'd2;
  localparam logic [2:0] FN_MUL    = 3'd3;
  localparam logic [2:0] FN_MVHI   = 3'd4;
  localparam logic [2:0] FN_MAX    = 3'd5;
  localparam logic [2:0] FN_MIN    = 3'd6;
  localparam logic [2:0] FN_RSHIFT = 3'd7;

  localparam int INST_W       = 32;
  localparam int INST_FN_LSB  = 29;
  localparam int INST_FN_W    = 3;
  localparam int INST_SRC_BIT = 28;
  localparam int INST_REP_LSB = 16;
  localparam int INST_REP_W   = 12;
  localparam int INST_IMM_LSB = 0;
  localparam int INST_IMM_W   = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [INST_FN_W-1:0]  fn;
    logic                  src;
    logic [INST_REP_W-1:0] rpt;
    logic [INST_IMM_W-1:0] imm;
  } inst_fields_t;

endpackage

// File: rtl/pu_inst_decode.sv
// Splits a PU ALU instruction word into fn, src, repeat and imm fields.
// Latency: combinational. Backpressure: none, pure decode.
// Feeds the issue FSM, which latches the fields on instruction accept.
module pu_inst_decode
  import pu_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output inst_fields_t      fields
);

  always_comb begin
    fields.fn  = inst[INST_FN_LSB +: INST_FN_W];
    fields.src = inst[INST_SRC_BIT];
    fields.rpt = inst[INST_REP_LSB +: INST_REP_W];
    fields.imm = inst[INST_IMM_LSB +: INST_IMM_W];
  end

endmodule

// File: rtl/pu_alu_issue.sv
// Issues each accepted instruction over repeat+1 operand pairs to the PU ALU.
// Latency: fn_valid in the issue cycle, result valid one cycle later.
// Backpressure: operands stall while a result is held by out_ready; optional stats under PU_ALU_ISSUE_STATS_EN.
module pu_alu_issue
  import pu_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ACC_DATA_WIDTH = 32,
  parameter int IMM_WIDTH      = 16,
  parameter int FN_WIDTH       = 3,
  parameter int REPEAT_WIDTH   = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inst_valid,
  output logic                      inst_ready,
  input  logic [31:0]               inst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ACC_DATA_WIDTH-1:0] in_data0,
  input  logic [DATA_WIDTH-1:0]     in_data1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      fn_valid,
  output logic [FN_WIDTH-1:0]       fn,
  output logic [IMM_WIDTH-1:0]      imm,
  output logic                      alu_in1_src,
  output logic [ACC_DATA_WIDTH-1:0] alu_in0,
  output logic [DATA_WIDTH-1:0]     alu_in1,
`ifdef PU_ALU_ISSUE_STATS_EN
  output logic [31:0]               stat_issue_count,
  output logic [31:0]               stat_stall_count,
`endif
  input  logic [ACC_DATA_WIDTH-1:0] alu_out
);

  inst_fields_t dec;

  logic [0:0]              state;
  logic [FN_WIDTH-1:0]     fn_q;
  logic [IMM_WIDTH-1:0]    imm_q;
  logic                    src_q;
  logic [REPEAT_WIDTH-1:0] count_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic                    issue;
  logic                    last_issue;

  pu_inst_decode u_dec (
    .inst   (inst),
    .fields (dec)
  );

  // A held result blocks the next issue so alu_out stays stable until drained.
  assign inst_ready = (state == ST_IDLE);
  assign in_ready   = (state == ST_RUN) && (!out_valid_q || out_ready);
  assign issue      = in_valid && in_ready;
  assign last_issue = (count_q == '0);

  assign fn_valid    = issue;
  assign fn          = fn_q;
  assign imm         = imm_q;
  assign alu_in1_src = src_q;
  assign alu_in0     = in_data0;
  assign alu_in1     = in_data1;

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = alu_out;
  assign busy      = (state == ST_RUN) || out_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      fn_q    <= '0;
      imm_q   <= '0;
      src_q   <= 1'b0;
      count_q <= '0;
    end else if (state == ST_IDLE) begin
      if (inst_valid) begin
        fn_q    <= dec.fn;
        imm_q   <= dec.imm;
        src_q   <= dec.src;
        count_q <= dec.rpt;
        state   <= ST_RUN;
      end
    end else if (issue) begin
      if (last_issue) begin
        state <= ST_IDLE;
      end else begin
        count_q <= count_q - {{(REPEAT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_last_q  <= last_issue;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef PU_ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issue_count <= '0;
      stat_stall_count <= '0;
    end else begin
      if (issue) begin
        stat_issue_count <= stat_issue_count + 32'd1;
      end
      if ((state == ST_RUN) && in_valid && !in_ready) begin
        stat_stall_count <= stat_stall_count + 32'd1;
      end
    end
  end
`endif

endmodule
